renkon_net_loader: RTL and testbench

RENKON_NET_LOADER -- requirements
Module: renkon_net_loader

---
 rtl/renkon_net_loader.sv | 119 +++++++++++
 tb/tb_renkon_net_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/renkon_net_loader.sv
// Streams one layer of weights into the per-core net memories, then hands off to renkon_top for compute.
// Optional feature: define RENKON_NET_CKSUM_EN to add a running checksum output (cksum) over the streamed words.
module renkon_net_loader #(
  parameter int DWIDTH         = 16,
  parameter int RENKON_CORE    = 8,
  parameter int RENKON_CORELOG = 3,
  parameter int RENKON_NETSIZE = 11
) (
  input  logic                          clk,
  input  logic                          xrst,
  input  logic                          start,
  input  logic [RENKON_NETSIZE:0]       word_cnt,
  input  logic [RENKON_CORELOG:0]       core_cnt,
  input  logic                          s_valid,
  input  logic signed [DWIDTH-1:0]      s_data,
  output logic                          s_ready,
  output logic [RENKON_CORELOG-1:0]     net_sel,
  output logic                          net_we,
  output logic [RENKON_NETSIZE-1:0]     net_addr,
  output logic signed [DWIDTH-1:0]      net_wdata,
  output logic                          req,
  input  logic                          ack,
  output logic                          busy,
  output logic                          done
`ifdef RENKON_NET_CKSUM_EN
  ,
  output logic [DWIDTH-1:0]             cksum
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [RENKON_NETSIZE:0]     W_ONE    = 1;
  localparam logic [RENKON_CORELOG:0]     C_ONE    = 1;
  localparam logic [RENKON_NETSIZE-1:0]   A_ONE    = 1;
  localparam logic [RENKON_CORELOG-1:0]   S_ONE    = 1;
  localparam logic [RENKON_CORELOG:0]     CORE_MAX = (RENKON_CORELOG+1)'(RENKON_CORE);

  logic [2:0]                  state;
  logic [RENKON_NETSIZE:0]     wcnt;
  logic [RENKON_CORELOG:0]     ccnt;
  logic [RENKON_CORELOG-1:0]   sel;
  logic [RENKON_NETSIZE-1:0]   addr;
  logic                        hs;
  logic                        last_word;
  logic                        last_core;

  assign s_ready   = (state == S_LOAD);
  assign hs        = s_valid && s_ready;
  assign last_word = ({1'b0, addr} == (wcnt - W_ONE));
  assign last_core = ({1'b0, sel} == (ccnt - C_ONE));
  assign busy      = (state != S_IDLE);
  assign req       = (state == S_ISSUE);
  assign done      = (state == S_FIN);

  // NOTE: sequential state uses <= only, so every register here samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      ccnt      <= '0;
      sel       <= '0;
      addr      <= '0;
      net_we    <= 1'b0;
      net_sel   <= '0;
      net_addr  <= '0;
      net_wdata <= '0;
    end else begin
      net_we <= hs;
      if (hs) begin
        net_sel   <= sel;
        net_addr  <= addr;
        net_wdata <= s_data;
      end
      case (state)
        S_IDLE: if (start) begin
          wcnt  <= word_cnt;
          // Requests for more cores than exist are limited to the cores present.
          ccnt  <= (core_cnt > CORE_MAX) ? CORE_MAX : core_cnt;
          sel   <= '0;
          addr  <= '0;
          state <= (word_cnt == '0 || core_cnt == '0) ? S_ISSUE : S_LOAD;
        end
        S_LOAD: if (hs) begin
          if (last_word) begin
            addr <= '0;
            sel  <= sel + S_ONE;
            if (last_core) state <= S_DRAIN;
          end else begin
            addr <= addr + A_ONE;
          end
        end
        S_DRAIN: state <= S_ISSUE;
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  if (ack) state <= S_FIN;
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RENKON_NET_CKSUM_EN
  always_ff @(posedge clk) begin
    if (!xrst) begin
      cksum <= '0;
    end else if (state == S_IDLE && start) begin
      cksum <= '0;
    end else if (hs) begin
      cksum <= cksum + $unsigned(s_data);
    end
  end
`endif

endmodule

// File: tb/tb_renkon_net_loader.sv
// Directed bench for renkon_net_loader: write sequence, handshake gaps, empty layer, ignored controls, mid-layer reset.
// Build with RENKON_NET_CKSUM_EN defined to also cover the checksum output.
module tb_renkon_net_loader;
  localparam int DW = 16;
  localparam int CL = 3;
  localparam int NS = 11;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic ack = 1'b0;
  logic [NS:0] word_cnt = '0;
  logic [CL:0] core_cnt = '0;
  logic signed [DW-1:0] s_data = '0;
  logic s_ready, net_we, req, busy, done;
  logic [CL-1:0] net_sel;
  logic [NS-1:0] net_addr;
  logic signed [DW-1:0] net_wdata;
`ifdef RENKON_NET_CKSUM_EN
  logic [DW-1:0] cksum;
`endif

  renkon_net_loader #(.DWIDTH(DW), .RENKON_CORE(8), .RENKON_CORELOG(CL), .RENKON_NETSIZE(NS)) dut (
    .clk(clk), .xrst(xrst), .start(start), .word_cnt(word_cnt), .core_cnt(core_cnt),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .net_sel(net_sel), .net_we(net_we),
    .net_addr(net_addr), .net_wdata(net_wdata), .req(req), .ack(ack), .busy(busy), .done(done)
`ifdef RENKON_NET_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sel;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  hs_n = 0;
  int  req_n = 0;
  int  done_n = 0;
  int  req_cyc = 0;
  logic hs_q = 1'b0;
  bit  chk_we = 1'b0;
  wr_t wq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference handshake, gated by reset, used to predict net_we one cycle later.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hs_q <= xrst && s_valid && s_ready;
    if (xrst && s_valid && s_ready) hs_n <= hs_n + 1;
  end

  always @(negedge clk) begin
    if (net_we) wq.push_back('{32'(net_sel), 32'(net_addr), {16'b0, net_wdata}, cyc});
    if (req) begin
      req_n++;
      req_cyc = cyc;
    end
    if (done) done_n++;
    if (chk_we) check("we_follows_hs", 32'(net_we), 32'(hs_q));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input int wc, input int cc);
    word_cnt = (NS+1)'(wc);
    core_cnt = (CL+1)'(cc);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gap, input logic [15:0] d[$]);
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = d[k];
      step();
      if (gap) begin
        s_valid = 1'b0;
        s_data  = 16'h5A5A;
        step();
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_req(input int base);
    int k;
    k = 0;
    while (req_n == base && k < 20) begin
      step();
      k++;
    end
    check("req_seen", 32'(req_n - base), 1);
  endtask

  task automatic finish_layer(input bit poke_start);
    ack = 1'b1;
    step();
    ack = 1'b0;
    if (poke_start) begin
      start = 1'b1;
      word_cnt = '0;
      core_cnt = 4'd1;
    end
    sample();
    check("done_pulse", 32'(done), 1);
    check("busy_fin", 32'(busy), 1);
    step();
    start = 1'b0;
    sample();
    check("done_clear", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  task automatic check_writes(input int wb, input int wc, input int cc, input logic [15:0] d[$], input bit consec);
    check("wr_count", 32'(wq.size() - wb), 32'(wc * cc));
    for (int i = 0; i < wc * cc && wb + i < wq.size(); i++) begin
      check("wr_sel", wq[wb+i].sel, 32'(i / wc));
      check("wr_addr", wq[wb+i].addr, 32'(i % wc));
      check("wr_data", wq[wb+i].data, {16'b0, d[i]});
      if (consec && i > 0) check("wr_consec", 32'(wq[wb+i].cyc - wq[wb+i-1].cyc), 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_net_we"}, 32'(net_we), 0);
    check({tag, "_req"}, 32'(req), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_net_sel"}, 32'(net_sel), 0);
    check({tag, "_net_addr"}, 32'(net_addr), 0);
    check({tag, "_net_wdata"}, {16'b0, net_wdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] d1[$];
    logic [15:0] d4[$];
    logic [15:0] d5a[$];
    logic [15:0] d5[$];
    int wb, rb, db, hb;

    d1  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    d4  = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    d5a = '{16'h0101, 16'h0202, 16'h0303};
    d5  = '{16'h7FFF, 16'h0002};

    // Reset state
    step();
    step();
    sample();
    check_reset_outputs("reset");
    xrst = 1'b1;
    step();
    chk_we = 1'b1;

    // Layer 1: 4 words x 2 cores, s_valid held high
    wb = wq.size(); rb = req_n; db = done_n; hb = hs_n;
    do_start(4, 2);
    sample();
    check("l1_busy", 32'(busy), 1);
    check("l1_s_ready", 32'(s_ready), 1);
    feed(8, 1'b0, d1);
    wait_req(rb);
    check_writes(wb, 4, 2, d1, 1'b1);
    check("l1_req_after_last_we", 32'(req_cyc - wq[wq.size()-1].cyc), 1);
    finish_layer(1'b0);
    check("l1_hs_count", 32'(hs_n - hb), 8);
    check("l1_req_count", 32'(req_n - rb), 1);
    check("l1_done_count", 32'(done_n - db), 1);

    // Layer 2: same load with s_valid toggling
    wb = wq.size(); rb = req_n; db = done_n;
    do_start(4, 2);
    feed(8, 1'b1, d1);
    wait_req(rb);
    check_writes(wb, 4, 2, d1, 1'b0);
    check("l2_req_after_last_we", 32'(req_cyc - wq[wq.size()-1].cyc), 1);
    finish_layer(1'b1);
    check("l2_done_count", 32'(done_n - db), 1);

    // Layer 3: word_cnt=0 skips straight to compute; stream must not be consumed
    wb = wq.size(); rb = req_n; db = done_n; hb = hs_n;
    s_valid = 1'b1;
    s_data = 16'h1234;
    do_start(0, 1);
    sample();
    check("l3_s_ready", 32'(s_ready), 0);
    check("l3_req_first", 32'(req), 1);
    check("l3_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      sample();
      check("l3_wait_req", 32'(req), 0);
      check("l3_wait_done", 32'(done), 0);
      check("l3_wait_busy", 32'(busy), 1);
    end
    finish_layer(1'b0);
    s_valid = 1'b0;
    check("l3_hs_count", 32'(hs_n - hb), 0);
    check("l3_wr_count", 32'(wq.size() - wb), 0);
    check("l3_req_count", 32'(req_n - rb), 1);

    // Layer 4: stray ack in IDLE/LOAD, stray start in LOAD/WAIT
    ack = 1'b1;
    step();
    ack = 1'b0;
    sample();
    check("l4_idle_ack_busy", 32'(busy), 0);
    wb = wq.size(); rb = req_n; db = done_n;
    do_start(2, 2);
    s_valid = 1'b1;
    s_data = d4[0];
    start = 1'b1;
    word_cnt = 12'd1;
    core_cnt = 4'd1;
    ack = 1'b1;
    step();
    start = 1'b0;
    ack = 1'b0;
    feed(3, 1'b0, d4[1:$]);
    wait_req(rb);
    start = 1'b1;
    word_cnt = '0;
    step();
    start = 1'b0;
    sample();
    check("l4_wait_busy", 32'(busy), 1);
    check("l4_wait_done", 32'(done), 0);
    finish_layer(1'b0);
    for (int i = 0; i < 3; i++) step();
    check_writes(wb, 2, 2, d4, 1'b1);
    check("l4_req_count", 32'(req_n - rb), 1);
    check("l4_done_count", 32'(done_n - db), 1);

    // Layer 5: reset after 3 of 8 words, then a fresh 2x1 layer
    rb = req_n; hb = hs_n;
    do_start(4, 2);
    feed(3, 1'b0, d5a);
    s_valid = 1'b1;
    xrst = 1'b0;
    step();
    sample();
    check_reset_outputs("midreset");
    xrst = 1'b1;
    wb = wq.size();
    for (int i = 0; i < 5; i++) step();
    s_valid = 1'b0;
    check("l5_no_stale_req", 32'(req_n - rb), 0);
    check("l5_no_stale_we", 32'(wq.size() - wb), 0);
    check("l5_hs_before_reset", 32'(hs_n - hb), 3);
    hb = hs_n;
    do_start(2, 1);
    feed(2, 1'b0, d5);
    s_valid = 1'b1;
    s_data = 16'hFFFF;
    sample();
`ifdef RENKON_NET_CKSUM_EN
    check("l5_cksum_drain", 32'(cksum), 32'h8001);
`endif
    wait_req(rb);
    s_valid = 1'b0;
    check("l5_hs_count", 32'(hs_n - hb), 2);
    check_writes(wb, 2, 1, d5, 1'b1);
    finish_layer(1'b0);
`ifdef RENKON_NET_CKSUM_EN
    check("l5_cksum_hold", 32'(cksum), 32'h8001);
`endif
    check("l5_req_count", 32'(req_n - rb), 1);

    chk_we = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
